// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus definitions: FSM state encoding, master ids, abort read value.
// Reused by the CPU and loader bus code as well as the arbiter.
package mem_bus_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DBG = 1'b1
  } master_id_e;

  // Read data returned to a master whose access was aborted by the watchdog
  localparam logic [DW_DEF-1:0] RD_ABORT_VAL = '1;

  function automatic master_id_e other_master(input master_id_e id);
    return (id == M_CPU) ? M_DBG : M_CPU;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Simple request/ready memory bus. The same bundle is used on the master links
// (arbiter is the slave) and on the memory link (arbiter is the master, req acts
// as the memory access strobe).
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (output req, we, addr, wdata, input  rdata, ready);
  modport slave  (input  req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the master that
// did not win last time gets the bus.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] i_req,
  input  master_id_e i_last,
  output master_id_e o_gnt,
  output logic       o_vld
);

  // Combinational winner selection
  always_comb begin
    o_vld = |i_req;
    o_gnt = M_CPU;
    case (i_req)
      2'b01:   o_gnt = M_CPU;
      2'b10:   o_gnt = M_DBG;
      2'b11:   o_gnt = other_master(i_last);
      default: o_gnt = M_CPU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port memory between the CPU (m0) and the debug/loader
// master (m1). One access in flight, registered completion to the winner,
// watchdog abort if memory never answers.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master mem,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  bus_state_e    r_state, w_state_nxt;
  master_id_e    r_last, r_win, w_gnt;
  logic          w_gnt_vld;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_last_wait;

  // r_cnt counts WAIT cycles already spent, so the current cycle is the
  // TIMEOUT_CYC-th one when r_cnt sits one below the limit.
  assign w_last_wait = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign timeout_err = r_err;

  rr_arb2 u_arb (
    .i_req  ({m1.req, m0.req}),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_vld  (w_gnt_vld)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and all bus outputs; outputs decode from registers only, so an
  // async reset drops the bus immediately.
  always_comb begin
    w_state_nxt = r_state;
    mem.req     = 1'b0;
    mem.we      = 1'b0;
    mem.addr    = '0;
    mem.wdata   = '0;
    m0.ready    = 1'b0;
    m0.rdata    = '0;
    m1.ready    = 1'b0;
    m1.rdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mem.req   = 1'b1;
        mem.we    = r_we;
        mem.addr  = r_addr;
        mem.wdata = r_wdata;
        if (mem.ready || w_last_wait) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // No grant here: the DONE/IDLE bubble keeps ready a clean single pulse
        w_state_nxt = ST_IDLE;
        if (r_win == M_CPU) begin
          m0.ready = 1'b1;
          m0.rdata = r_rdata;
        end else begin
          m1.ready = 1'b1;
          m1.rdata = r_rdata;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's request at grant so live master inputs never reach memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= M_DBG;
      r_win   <= M_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && w_gnt_vld) begin
      r_last <= w_gnt;
      r_win  <= w_gnt;
      if (w_gnt == M_CPU) begin
        r_we    <= m0.we;
        r_addr  <= m0.addr;
        r_wdata <= m0.wdata;
      end else begin
        r_we    <= m1.we;
        r_addr  <= m1.addr;
        r_wdata <= m1.wdata;
      end
    end
  end

  // Watchdog counter: cleared at grant, advances every WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_cnt <= '0;
    else if (r_state == ST_IDLE && w_gnt_vld)  r_cnt <= '0;
    else if (r_state == ST_WAIT)               r_cnt <= r_cnt + CW'(1);
  end

  // Completion data and sticky abort flag; a memory answer in the final
  // allowed cycle takes priority over the abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (mem.ready) begin
        r_rdata <= mem.rdata;
      end else if (w_last_wait) begin
        r_rdata <= {DW{1'b1}};
        r_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a default-timeout instance for the
// arbitration/latency tests and a TIMEOUT_CYC=4 instance for the watchdog.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic terr, t_terr;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(16), .DW(16)) m0 ();
  mem_bus_arbiter_if #(.AW(16), .DW(16)) m1 ();
  mem_bus_arbiter_if #(.AW(16), .DW(16)) mem ();
  mem_bus_arbiter_if #(.AW(16), .DW(16)) t0 ();
  mem_bus_arbiter_if #(.AW(16), .DW(16)) t1 ();
  mem_bus_arbiter_if #(.AW(16), .DW(16)) tmem ();

  mem_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .mem(mem), .timeout_err(terr)
  );

  mem_bus_arbiter #(.AW(16), .DW(16), .TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .m0(t0), .m1(t1), .mem(tmem), .timeout_err(t_terr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access starting in an IDLE cycle with requests already presented
  task automatic serve(input string tag, input logic win, input int lat,
                       input logic [15:0] e_addr, input logic e_we, input logic [15:0] e_wdata,
                       input logic [15:0] mdata, input logic drop, input logic wiggle);
    tick();
    for (int k = 1; k <= lat; k++) begin
      chk({tag, " en"},    mem.req,   1);
      chk({tag, " addr"},  mem.addr,  e_addr);
      chk({tag, " we"},    mem.we,    e_we);
      chk({tag, " wdata"}, mem.wdata, e_wdata);
      chk({tag, " rdy_w"}, {m1.ready, m0.ready}, 0);
      if (wiggle && k == 1) m0.addr = 16'h0ABC;
      if (k == lat) begin
        mem.ready = 1'b1;
        mem.rdata = mdata;
      end
      tick();
    end
    mem.ready = 1'b0;
    mem.rdata = 16'hDEAD;
    chk({tag, " en_done"}, mem.req, 0);
    chk({tag, " rdy"},     win ? m1.ready : m0.ready, 1);
    chk({tag, " rdata"},   win ? m1.rdata : m0.rdata, mdata);
    chk({tag, " lose"},    win ? {m0.ready, m0.rdata} : {m1.ready, m1.rdata}, 0);
    if (drop) begin
      m0.req = 1'b0;
      m1.req = 1'b0;
    end
    tick();
    chk({tag, " bubble"}, {mem.req, m1.ready, m0.ready}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m0.req = 0; m0.we = 0; m0.addr = 0; m0.wdata = 0;
    m1.req = 0; m1.we = 0; m1.addr = 0; m1.wdata = 0;
    mem.ready = 0; mem.rdata = 0;
    t0.req = 0; t0.we = 0; t0.addr = 0; t0.wdata = 0;
    t1.req = 0; t1.we = 0; t1.addr = 0; t1.wdata = 0;
    tmem.ready = 0; tmem.rdata = 0;

    // Reset state
    do_reset();
    chk("rst outs", {mem.req, mem.we, m0.ready, m1.ready, terr, t_terr}, 0);
    chk("rst addr", mem.addr, 0);

    // 1: single m0 read, zero-wait memory
    m0.req = 1; m0.we = 0; m0.addr = 16'h0010;
    serve("t1", 1'b0, 1, 16'h0010, 1'b0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);

    // 2: both request continuously, alternating grants from reset
    do_reset();
    m0.req = 1; m0.we = 0; m0.addr = 16'h0100; m0.wdata = 16'h0000;
    m1.req = 1; m1.we = 1; m1.addr = 16'h0200; m1.wdata = 16'h2222;
    serve("t2a", 1'b0, 1, 16'h0100, 1'b0, 16'h0000, 16'hA0A0, 1'b0, 1'b0);
    serve("t2b", 1'b1, 1, 16'h0200, 1'b1, 16'h2222, 16'hB1B1, 1'b0, 1'b0);
    serve("t2c", 1'b0, 1, 16'h0100, 1'b0, 16'h0000, 16'hC2C2, 1'b0, 1'b0);
    serve("t2d", 1'b1, 1, 16'h0200, 1'b1, 16'h2222, 16'hD3D3, 1'b1, 1'b0);

    // 3: m1 write with five-cycle memory wait
    m1.req = 1; m1.we = 1; m1.addr = 16'h8000; m1.wdata = 16'h1234;
    serve("t3", 1'b1, 5, 16'h8000, 1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0);

    // 4a: answer in the last allowed cycle beats the watchdog
    t0.req = 1; t0.we = 0; t0.addr = 16'h0020;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("t4a en", tmem.req, 1);
      if (k == 4) begin
        tmem.ready = 1; tmem.rdata = 16'h1357;
      end
      tick();
    end
    tmem.ready = 0;
    chk("t4a rdy", {t0.ready, t0.rdata}, {1'b1, 16'h1357});
    chk("t4a err", t_terr, 0);
    t0.req = 0;
    tick();
    // 4b: memory silent, abort after four WAIT cycles
    t0.req = 1; t0.addr = 16'h0030;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("t4b en", tmem.req, 1);
      chk("t4b err_w", t_terr, 0);
      tick();
    end
    chk("t4b en_done", tmem.req, 0);
    chk("t4b rdy", {t0.ready, t0.rdata}, {1'b1, 16'hFFFF});
    chk("t4b err", t_terr, 1);
    t0.req = 0;
    tick();
    chk("t4b idle", {t0.ready, t_terr}, 2'b01);
    // 4c: later good access leaves the error sticky
    t0.req = 1; t0.addr = 16'h0040;
    tick();
    tmem.ready = 1; tmem.rdata = 16'h5555;
    tick();
    tmem.ready = 0;
    chk("t4c rdy", {t0.ready, t0.rdata}, {1'b1, 16'h5555});
    chk("t4c err", t_terr, 1);
    t0.req = 0;
    tick();
    chk("t4c err2", t_terr, 1);

    // 6: master address changes mid-WAIT, then stray mem_ready while idle
    m0.req = 1; m0.we = 0; m0.addr = 16'h0040; m0.wdata = 16'h0000;
    serve("t6", 1'b0, 3, 16'h0040, 1'b0, 16'h0000, 16'h4444, 1'b1, 1'b1);
    mem.ready = 1; mem.rdata = 16'h7777;
    tick();
    chk("t6 stray1", {mem.req, m1.ready, m0.ready}, 0);
    tick();
    chk("t6 stray2", {mem.req, m1.ready, m0.ready}, 0);
    mem.ready = 0;
    tick();
    chk("t6 stray3", {m1.ready, m0.ready, m0.rdata}, 0);

    // 5: async reset mid-WAIT, then m0 must win the tie again
    m0.req = 1; m0.we = 0; m0.addr = 16'h0060;
    tick();
    chk("t5 en", mem.req, 1);
    #2 rst_n = 0;
    #1;
    chk("t5 rst en", {mem.req, mem.we, m0.ready, m1.ready, terr, t_terr}, 0);
    chk("t5 rst addr", mem.addr, 0);
    #2 rst_n = 1;
    m1.req = 1; m1.we = 0; m1.addr = 16'h0070;
    serve("t5", 1'b0, 1, 16'h0060, 1'b0, 16'h0000, 16'h6060, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
